// File: rtl/lock_sequencer.sv
// Canal lock sequencer: moves one gondola at a time between the low
// (left) and high (right) sides, driving gates and chamber water level.
module lock_sequencer #(
    parameter int LEVEL_MAX     = 8,
    parameter int GATE_TICKS    = 4,
    parameter int TRANSIT_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive_req,
    input  logic       depart_req,
    input  logic       hold,
    output logic       grant_arr,
    output logic       grant_dep,
    output logic       gate_l_open,
    output logic       gate_r_open,
    output logic       fill,
    output logic       drain,
    output logic [7:0] level,
    output logic       in_chamber,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0]  TOP          = 8'(LEVEL_MAX);
    localparam logic [31:0] GATE_LAST    = 32'(GATE_TICKS - 1);
    localparam logic [31:0] TRANSIT_LAST = 32'(TRANSIT_TICKS - 1);

    typedef enum logic [3:0] {
        IDLE,
        ALIGN,
        OPEN_IN,
        ENTER,
        CLOSE_IN,
        SHIFT,
        OPEN_OUT,
        EXIT,
        CLOSE_OUT
    } state_t;

    state_t      state;
    logic [7:0]  lvl;
    logic [31:0] timer;
    logic        pend_arr;
    logic        pend_dep;
    // dir / last_dir: 0 = arrival, 1 = departure
    logic        dir;
    logic        last_dir;

    logic        take_arr;
    logic        take_dep;
    logic        moving;
    logic        step_up;
    logic        step_dn;
    logic        gate_end;
    logic        transit_end;
    logic        entry_phase;
    logic        exit_phase;
    logic [7:0]  entry_lvl;
    logic [7:0]  exit_lvl;
    logic [7:0]  new_entry;
    logic [7:0]  target;
    logic [7:0]  lvl_next;

    // Arbitration, level stepping and phase-end decode
    always_comb begin
        take_arr    = (state == IDLE) && !hold && pend_arr
                      && (!pend_dep || last_dir);
        take_dep    = (state == IDLE) && !hold && pend_dep
                      && (!pend_arr || !last_dir);
        entry_lvl   = dir ? TOP : 8'd0;
        exit_lvl    = dir ? 8'd0 : TOP;
        new_entry   = take_dep ? TOP : 8'd0;
        target      = (state == ALIGN) ? entry_lvl : exit_lvl;
        moving      = !hold && ((state == ALIGN) || (state == SHIFT));
        step_up     = moving && (lvl < target);
        step_dn     = moving && (lvl > target);
        lvl_next    = lvl;
        if (step_up) begin
            lvl_next = lvl + 8'd1;
        end else if (step_dn) begin
            lvl_next = lvl - 8'd1;
        end
        gate_end    = (timer == GATE_LAST);
        transit_end = (timer == TRANSIT_LAST);
        entry_phase = (state == OPEN_IN) || (state == ENTER);
        exit_phase  = (state == OPEN_OUT) || (state == EXIT);
    end

    // Sequencer state, level, timers and request latches
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            lvl      <= 8'd0;
            timer    <= '0;
            pend_arr <= 1'b0;
            pend_dep <= 1'b0;
            dir      <= 1'b0;
            last_dir <= 1'b1;
        end else begin
            pend_arr <= !take_arr && (pend_arr || arrive_req);
            pend_dep <= !take_dep && (pend_dep || depart_req);
            if (!hold) begin
                unique case (state)
                    IDLE: begin
                        if (take_arr || take_dep) begin
                            dir      <= take_dep;
                            last_dir <= take_dep;
                            timer    <= '0;
                            if (lvl == new_entry) begin
                                state <= OPEN_IN;
                            end else begin
                                state <= ALIGN;
                            end
                        end
                    end
                    ALIGN: begin
                        lvl <= lvl_next;
                        if (lvl_next == entry_lvl) begin
                            state <= OPEN_IN;
                        end
                    end
                    OPEN_IN: begin
                        if (gate_end) begin
                            timer <= '0;
                            state <= ENTER;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    ENTER: begin
                        if (transit_end) begin
                            timer <= '0;
                            state <= CLOSE_IN;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    CLOSE_IN: begin
                        if (gate_end) begin
                            timer <= '0;
                            state <= SHIFT;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    SHIFT: begin
                        lvl <= lvl_next;
                        if (lvl_next == exit_lvl) begin
                            state <= OPEN_OUT;
                        end
                    end
                    OPEN_OUT: begin
                        if (gate_end) begin
                            timer <= '0;
                            state <= EXIT;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    EXIT: begin
                        if (transit_end) begin
                            timer <= '0;
                            state <= CLOSE_OUT;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    CLOSE_OUT: begin
                        if (gate_end) begin
                            timer <= '0;
                            state <= IDLE;
                        end else begin
                            timer <= timer + 32'd1;
                        end
                    end
                    default: begin
                        timer <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Output decode; everything forced low while reset is held
    always_comb begin
        grant_arr   = reset && take_arr;
        grant_dep   = reset && take_dep;
        gate_l_open = reset && (dir ? exit_phase : entry_phase);
        gate_r_open = reset && (dir ? entry_phase : exit_phase);
        fill        = reset && step_up;
        drain       = reset && step_dn;
        level       = reset ? lvl : 8'd0;
        in_chamber  = reset && ((state == CLOSE_IN) || (state == SHIFT)
                      || (state == OPEN_OUT));
        busy        = reset && (state != IDLE);
        done        = reset && !hold && (state == CLOSE_OUT) && gate_end;
    end

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: per-cycle vector table for whole transits,
// plus hand sequences for hold, busy-time requests and mid-transit reset.
module tb_lock_sequencer;

    localparam int LM = 4;
    localparam int GT = 2;
    localparam int TT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arrive_req = 1'b0;
    logic       depart_req = 1'b0;
    logic       hold = 1'b0;
    logic       grant_arr;
    logic       grant_dep;
    logic       gate_l_open;
    logic       gate_r_open;
    logic       fill;
    logic       drain;
    logic [7:0] level;
    logic       in_chamber;
    logic       busy;
    logic       done;

    lock_sequencer #(
        .LEVEL_MAX(LM),
        .GATE_TICKS(GT),
        .TRANSIT_TICKS(TT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .arrive_req(arrive_req),
        .depart_req(depart_req),
        .hold(hold),
        .grant_arr(grant_arr),
        .grant_dep(grant_dep),
        .gate_l_open(gate_l_open),
        .gate_r_open(gate_r_open),
        .fill(fill),
        .drain(drain),
        .level(level),
        .in_chamber(in_chamber),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // {grant_arr, grant_dep, gl, gr, fill, drain, in_chamber, busy, done, level}
    logic [16:0] outs;
    assign outs = {grant_arr, grant_dep, gate_l_open, gate_r_open, fill,
                   drain, in_chamber, busy, done, level};

    typedef struct {
        logic        a;
        logic        d;
        logic        h;
        logic        r;
        logic [16:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic add(input logic a, input logic d, input logic h,
                       input logic r, input logic [8:0] f, input int lv);
        vec_t v;
        v.a = a;
        v.d = d;
        v.h = h;
        v.r = r;
        v.exp = {f, 8'(lv)};
        tbl.push_back(v);
    endtask

    // Expected per-cycle profile: grant cycle through last CLOSE_OUT cycle
    task automatic transit(input bit dep, input int start);
        int lv;
        int ent;
        bit gl_in;
        bit gr_in;
        lv = start;
        ent = dep ? LM : 0;
        gl_in = !dep;
        gr_in = dep;
        add(0, 0, 0, 1, {!dep, dep, 7'b0}, lv);
        while (lv != ent) begin
            add(0, 0, 0, 1, {4'b0, lv < ent, lv > ent, 3'b010}, lv);
            lv += (lv < ent) ? 1 : -1;
        end
        repeat (GT + TT) add(0, 0, 0, 1, {2'b00, gl_in, gr_in, 5'b00010}, lv);
        repeat (GT) add(0, 0, 0, 1, {6'b0, 3'b110}, lv);
        repeat (LM) begin
            add(0, 0, 0, 1, {4'b0, !dep, dep, 3'b110}, lv);
            lv += dep ? -1 : 1;
        end
        repeat (GT) add(0, 0, 0, 1, {2'b00, gr_in, gl_in, 5'b00110}, lv);
        repeat (TT) add(0, 0, 0, 1, {2'b00, gr_in, gl_in, 5'b00010}, lv);
        repeat (GT - 1) add(0, 0, 0, 1, {7'b0, 2'b10}, lv);
        add(0, 0, 0, 1, {7'b0, 2'b11}, lv);
    endtask

    initial begin
        int t;
        bit found;

        // reset, then arrival from level 0
        add(0, 0, 0, 0, 9'b0, 0);
        add(0, 0, 0, 0, 9'b0, 0);
        add(1, 0, 0, 1, 9'b0, 0);
        transit(0, 0);
        add(0, 0, 0, 1, 9'b0, LM);
        // departure from the high side
        add(0, 1, 0, 1, 9'b0, LM);
        transit(1, LM);
        add(0, 0, 0, 1, 9'b0, 0);
        // reset, then simultaneous requests: arrival first
        add(0, 0, 0, 0, 9'b0, 0);
        add(1, 1, 0, 1, 9'b0, 0);
        transit(0, 0);
        transit(1, LM);
        add(0, 0, 0, 1, 9'b0, 0);
        // arrival, then arrival again from the high side (ALIGN drains)
        add(1, 0, 0, 1, 9'b0, 0);
        transit(0, 0);
        add(1, 0, 0, 1, 9'b0, LM);
        transit(0, LM);
        add(0, 0, 0, 1, 9'b0, LM);
        // tie after an arrival: departure wins
        add(1, 1, 0, 1, 9'b0, LM);
        transit(1, LM);
        transit(0, 0);
        add(0, 0, 0, 1, 9'b0, LM);

        foreach (tbl[i]) begin
            arrive_req = tbl[i].a;
            depart_req = tbl[i].d;
            hold = tbl[i].h;
            reset = tbl[i].r;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
            chk($sformatf("inv%0d", i),
                32'({gate_l_open & gate_r_open, fill & drain,
                     int'(level) > LM}), 32'(0));
            @(posedge clk);
            #1;
        end

        // hold for 5 cycles in SHIFT, with an arrival request latched
        reset = 1'b0;
        arrive_req = 1'b0;
        depart_req = 1'b0;
        hold = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        arrive_req = 1'b1;
        @(posedge clk);
        #1 arrive_req = 1'b0;
        #1 chk("hold_grant", 32'(grant_arr), 32'(1));
        t = 0;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            #2 t++;
            if (fill && level == 8'd2) found = 1;
        end
        chk("hold_reach_shift", 32'(found), 32'(1));
        hold = 1'b1;
        #1;
        for (int h = 0; h < 5; h++) begin
            if (h > 0) begin
                @(posedge clk);
                #1 arrive_req = (h == 2);
                t++;
                #1;
            end
            chk($sformatf("hold_frz%0d", h),
                32'({fill, drain, grant_arr, done, in_chamber, busy, level}),
                32'({6'b000011, 8'd2}));
        end
        @(posedge clk);
        #1 hold = 1'b0;
        arrive_req = 1'b0;
        t++;
        #1;
        while (!done && t < 60) begin
            @(posedge clk);
            #2 t++;
        end
        chk("hold_done_at", 32'(t), 32'(23));
        @(posedge clk);
        #2 chk("busy_req_grant", 32'({grant_arr, grant_dep, busy}), 32'(3'b100));

        // departure latched while busy, then reset during EXIT
        @(posedge clk);
        #1 depart_req = 1'b1;
        @(posedge clk);
        #1 depart_req = 1'b0;
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(posedge clk);
            #2;
            if (gate_r_open && !in_chamber && busy) found = 1;
        end
        chk("reach_exit", 32'(found), 32'(1));
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("rst_outs", 32'(outs), 32'(0));
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("rst_after", 32'(outs), 32'(0));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #2 chk($sformatf("no_grant%0d", k), 32'(outs), 32'(0));
        end
        @(posedge clk);
        #1 arrive_req = 1'b1;
        @(posedge clk);
        #1 arrive_req = 1'b0;
        #1 chk("post_rst_grant",
               32'({grant_arr, grant_dep, busy, level}), 32'({3'b100, 8'd0}));
        @(posedge clk);
        #2 chk("post_rst_open",
               32'({gate_l_open, gate_r_open, busy}), 32'(3'b101));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 The block SHALL have parameter LEVEL_MAX, default 8, meaning the chamber level steps between the low side (0) and the high side (LEVEL_MAX); legal values are 1..255.
REQ-002 The block SHALL have parameter GATE_TICKS, default 4, meaning the number of cycles for a gate to open or close; legal values are at least 1.
REQ-003 The block SHALL have parameter TRANSIT_TICKS, default 8, meaning the number of cycles a gondola needs to enter or leave the chamber; legal values are at least 1.
REQ-004 The block SHALL have port clk, input, width 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, width 1, a synchronous active-low reset.
REQ-006 The block SHALL have port arrive_req, input, width 1: a gondola waits at the left (low) gate.
REQ-007 The block SHALL have port depart_req, input, width 1: a gondola waits at the right (high) gate.
REQ-008 The block SHALL have port hold, input, width 1: freeze sequencing.
REQ-009 The block SHALL have port grant_arr / grant_dep, outputs, width 1 each: a one-cycle pulse when a request is accepted.
REQ-010 The block SHALL have port gate_l_open / gate_r_open, outputs, width 1 each: the gate open commands.
REQ-011 The block SHALL have port fill / drain, outputs, width 1 each: the water level commands.
REQ-012 The block SHALL have port level, output, width 8: the current chamber level.
REQ-013 The block SHALL have port in_chamber, output, width 1: a gondola is held inside the closed chamber.
REQ-014 The block SHALL have port busy, output, width 1: a transit is in progress (state is not IDLE).
REQ-015 The block SHALL have port done, output, width 1: a one-cycle pulse when a transit completes.

Function
REQ-016 The block SHALL latch an asserted arrive_req or depart_req into its own pending flag at the clock edge; the flag SHALL hold until its grant and SHALL ignore re-assertion while set.
REQ-017 The block SHALL use the states IDLE, ALIGN, OPEN_IN, ENTER, CLOSE_IN, SHIFT, OPEN_OUT, EXIT, CLOSE_OUT.
REQ-018 In IDLE with a pending flag set, the block SHALL pulse the matching grant that cycle, clear that flag, record the direction, and leave IDLE at the next edge.
REQ-019 Direction rules SHALL be: arrival has entry side 0 via gate L and exit side LEVEL_MAX via gate R; departure is the mirror of arrival.
REQ-020 If level already equals the entry side, the block SHALL skip ALIGN and go directly to OPEN_IN; otherwise ALIGN SHALL step level by 1 per cycle toward the entry side.
REQ-021 OPEN_IN and CLOSE_IN SHALL last GATE_TICKS cycles each, ENTER SHALL last TRANSIT_TICKS cycles, and SHIFT SHALL step level by 1 per cycle to the exit side, lasting LEVEL_MAX cycles.
REQ-022 OPEN_OUT, EXIT and CLOSE_OUT SHALL mirror OPEN_IN, ENTER and CLOSE_IN on the exit gate, after which the state SHALL return to IDLE.
REQ-023 The entry gate open command SHALL be high in OPEN_IN and ENTER only; the exit gate open command SHALL be high in OPEN_OUT and EXIT only.
REQ-024 fill SHALL be high exactly in cycles where level increments, and drain exactly in cycles where level decrements.
REQ-025 in_chamber SHALL be high in CLOSE_IN, SHIFT and OPEN_OUT.
REQ-026 done SHALL be high on the last CLOSE_OUT cycle.
REQ-027 The following invariants SHALL hold in every cycle: gate_l_open and gate_r_open are never both high; fill and drain are never both high; a gate is open only when level equals its side value; level stays within 0..LEVEL_MAX with no wrap.
REQ-028 When both flags are pending in IDLE, the block SHALL grant the direction opposite to the last served direction (round-robin).
REQ-029 Requests arriving while busy SHALL be latched and served in a later IDLE cycle, including a request for the direction currently in service.
REQ-030 While hold is high, state, timers, level and pending flags SHALL freeze, except that new requests still latch.
REQ-031 While hold is high, fill and drain SHALL be 0, gate outputs SHALL keep their values, and grant and done SHALL be 0.

Reset
REQ-032 While reset=0 at an edge, the block SHALL set state to IDLE, level to 0, all pending flags to 0, timers to 0, and the last-served direction to departure, so arrival wins the first tie.
REQ-033 During reset, all outputs SHALL be 0, including when reset is asserted mid-transit.
REQ-034 After reset, the block SHALL behave as a fresh start: no grant before a new request.

Verification
REQ-035 Bench setup: parameters 4/2/3 (LEVEL_MAX/GATE_TICKS/TRANSIT_TICKS), level 0, arrive_req pulse -> grant_arr 1 cycle later; gate_l_open 5 cycles; fill 4 cycles with level 1..4; gate_r_open 5 cycles; done 18 cycles after grant; final level 4.
REQ-036 Next, depart_req at level 4 -> same profile mirrored with drain; final level 0.
REQ-037 Both requests in the same cycle after reset -> grant_arr first, grant_dep in the first IDLE cycle after its done; the second transit skips ALIGN since level is 4.
REQ-038 Arrival request with level 4 -> 4 drain cycles in ALIGN before gate_l_open; busy lasts 22 cycles.
REQ-039 hold high for 5 cycles during SHIFT -> level is frozen, fill is 0, and done is delayed by exactly 5 cycles.
REQ-040 reset=0 during EXIT -> next cycle all outputs are 0, level is 0, and pending is cleared; an arrive_req afterwards is granted normally.
